// File: rtl/inverter_bist_ctrl.sv
// Built-in self-test sequencer for a single-bit inverting gate.
// Optional STOP_ON_ERR_EN: end the run on the first mismatch.
module inverter_bist_ctrl #(
  parameter int N_PATTERNS    = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_out,
  output logic             dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] pattern_idx
);

  localparam int SW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SLAST =
    SW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PLAST =
    CNT_W'(N_PATTERNS - 1);
  localparam logic [CNT_W-1:0] EMAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [SW-1:0]    r_cnt;
  logic             r_dut_in;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_err;
  logic [CNT_W-1:0] r_idx;

  logic             w_mismatch;
  logic             w_last;
  logic             w_stop;
  logic [CNT_W-1:0] w_err_nxt;

  // A healthy inverter drives the complement of what we apply.
  assign w_mismatch = (dut_out == r_dut_in);
  assign w_last     = (r_idx == PLAST);
  assign w_err_nxt  = (w_mismatch && r_err != EMAX)
                    ? r_err + 1'b1 : r_err;

`ifdef STOP_ON_ERR_EN
  assign w_stop = w_last | w_mismatch;
`else
  assign w_stop = w_last;
`endif

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_dut_in <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_idx    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_DRIVE;
            r_cnt   <= '0;
            r_err   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        S_DRIVE: begin
          r_dut_in <= r_idx[0];
          r_cnt    <= '0;
          r_state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_cnt == SLAST) begin
            r_cnt   <= '0;
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          r_err <= w_err_nxt;
          if (w_stop) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == '0);
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_DRIVE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dut_in      = r_dut_in;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign err_count   = r_err;
  assign pattern_idx = r_idx;

endmodule

// File: tb/tb_inverter_bist_ctrl.sv
// Scoreboard bench for inverter_bist_ctrl.
// Handles builds with and without STOP_ON_ERR_EN.
module tb_inverter_bist_ctrl;

  typedef struct {
    int err;
    int pass;
    int idx;
    int edges;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- instance A: defaults ----------------
  logic       rst_a = 1'b1, start_a = 1'b0;
  logic       dout_a, din_a, busy_a, done_a, pass_a;
  logic [7:0] err_a, idx_a;
  int         mode_a = 0;  // 0 inverter, 1 stuck0, 2 stuck1

  assign dout_a = (mode_a == 0) ? ~din_a :
                  (mode_a == 1) ? 1'b0 : 1'b1;

  inverter_bist_ctrl u_a (
    .clk(clk), .rst(rst_a), .start(start_a),
    .dut_out(dout_a), .dut_in(din_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .pattern_idx(idx_a)
  );

  // ---------------- instance B: N=3, S=1, CNT_W=2 ----------------
  logic       rst_b = 1'b1, start_b = 1'b0;
  logic       din_b, busy_b, done_b, pass_b;
  logic [1:0] err_b, idx_b;

  inverter_bist_ctrl #(
    .N_PATTERNS(3), .SETTLE_CYCLES(1), .CNT_W(2)
  ) u_b (
    .clk(clk), .rst(rst_b), .start(start_b),
    .dut_out(din_b), .dut_in(din_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .pattern_idx(idx_b)
  );

  // ---------------- instance C: N=4, S=1, CNT_W=2 ----------------
  logic       start_c = 1'b0;
  logic       din_c, busy_c, done_c, pass_c;
  logic [1:0] err_c, idx_c;

  inverter_bist_ctrl #(
    .N_PATTERNS(4), .SETTLE_CYCLES(1), .CNT_W(2)
  ) u_c (
    .clk(clk), .rst(rst_b), .start(start_c),
    .dut_out(din_c), .dut_in(din_c),
    .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_count(err_c), .pattern_idx(idx_c)
  );

  exp_t q_a[$], q_b[$], q_c[$];
  int   s_a = 0, s_b = 0, s_c = 0;
  bit   chk_seq = 1'b0;

  task automatic check(input string nm,
                       input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic cmp_run(input string nm, input exp_t e,
                         input int err, input int pas,
                         input int idx, input int edges);
    check({nm, ".err"},   err,   e.err);
    check({nm, ".pass"},  pas,   e.pass);
    check({nm, ".idx"},   idx,   e.idx);
    check({nm, ".edges"}, edges, e.edges);
  endtask

  // Monitors: pop expectation when done rises.
  logic pd_a = 0, pd_b = 0, pd_c = 0;
  always @(negedge clk) begin
    if (done_a && !pd_a) begin
      if (q_a.size() == 0) check("A.unexpected_done", 1, 0);
      else cmp_run("A", q_a.pop_front(), int'(err_a),
                   int'(pass_a), int'(idx_a), cyc - s_a);
    end
    if (done_b && !pd_b) begin
      if (q_b.size() == 0) check("B.unexpected_done", 1, 0);
      else cmp_run("B", q_b.pop_front(), int'(err_b),
                   int'(pass_b), int'(idx_b), cyc - s_b);
    end
    if (done_c && !pd_c) begin
      if (q_c.size() == 0) check("C.unexpected_done", 1, 0);
      else cmp_run("C", q_c.pop_front(), int'(err_c),
                   int'(pass_c), int'(idx_c), cyc - s_c);
    end
    pd_a = done_a;
    pd_b = done_b;
    pd_c = done_c;
  end

  // Pattern sequence: in each SAMPLE cycle dut_in must equal k[0].
  always @(negedge clk) begin
    int r;
    r = cyc - s_a;
    if (chk_seq && busy_a && r > 0 && (r % 4) == 3) begin
      check("A.seq_din", int'(din_a), (r / 4) % 2);
      check("A.seq_idx", int'(idx_a), r / 4);
    end
  end

  // Start pulses are issued at negedge; record the sampling edge.
  task automatic pulse_a(input bit rec);
    @(negedge clk);
    start_a = 1'b1;
    if (rec) s_a = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic run_a(input int mode, input exp_t e);
    mode_a = mode;
    q_a.push_back(e);
    pulse_a(1'b1);
  endtask

  task automatic wait_a(input string nm);
    int n = 0;
    while (q_a.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q_a.size() != 0) begin
      check({nm, ".timeout"}, 1, 0);
      q_a.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_bc(input string nm);
    int n = 0;
    while ((q_b.size() != 0 || q_c.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q_b.size() != 0 || q_c.size() != 0) begin
      check({nm, ".timeout"}, 1, 0);
      q_b.delete();
      q_c.delete();
    end
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst.din",  int'(din_a),  0);
    check("rst.busy", int'(busy_a), 0);
    check("rst.done", int'(done_a), 0);
    check("rst.pass", int'(pass_a), 0);
    check("rst.err",  int'(err_a),  0);
    check("rst.idx",  int'(idx_a),  0);

    // Ideal inverter with sequence checking
    chk_seq = 1'b1;
    e = '{err: 0, pass: 1, idx: 7, edges: 32};
    run_a(0, e);
    wait_a("ideal");
    chk_seq = 1'b0;

    // Stuck-at-0 then stuck-at-1
`ifdef STOP_ON_ERR_EN
    e = '{err: 1, pass: 0, idx: 0, edges: 4};
    run_a(1, e);
    wait_a("sa0");
    e = '{err: 1, pass: 0, idx: 1, edges: 8};
    run_a(2, e);
    wait_a("sa1");
`else
    e = '{err: 4, pass: 0, idx: 7, edges: 32};
    run_a(1, e);
    wait_a("sa0");
    e = '{err: 4, pass: 0, idx: 7, edges: 32};
    run_a(2, e);
    wait_a("sa1");
`endif

    // Frozen in DONE
    mode_a = 0;
    repeat (5) @(negedge clk);
    check("hold.done", int'(done_a), 1);
`ifdef STOP_ON_ERR_EN
    check("hold.err", int'(err_a), 1);
    check("hold.idx", int'(idx_a), 1);
`else
    check("hold.err", int'(err_a), 4);
    check("hold.idx", int'(idx_a), 7);
`endif

    // Start in DONE after failing run: counters cleared
    e = '{err: 0, pass: 1, idx: 7, edges: 32};
    run_a(0, e);
    @(negedge clk);
    check("restart.err", int'(err_a), 0);
    check("restart.busy", int'(busy_a), 1);
    wait_a("restart");

    // Start re-pulsed while busy is ignored
    e = '{err: 0, pass: 1, idx: 7, edges: 32};
    run_a(0, e);
    repeat (4) @(negedge clk);
    pulse_a(1'b0);
    repeat (10) @(negedge clk);
    pulse_a(1'b0);
    wait_a("repulse");

    // Reset mid-run, in SETTLE of pattern 3
`ifdef STOP_ON_ERR_EN
    mode_a = 0;
`else
    mode_a = 1;
`endif
    pulse_a(1'b1);
    while (cyc - s_a < 13) @(negedge clk);
    check("pre_rst.idx", int'(idx_a), 3);
    check("pre_rst.din", int'(din_a), 1);
    rst_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    start_a = 1'b0;
    check("mid_rst.din",  int'(din_a),  0);
    check("mid_rst.busy", int'(busy_a), 0);
    check("mid_rst.done", int'(done_a), 0);
    check("mid_rst.pass", int'(pass_a), 0);
    check("mid_rst.err",  int'(err_a),  0);
    check("mid_rst.idx",  int'(idx_a),  0);
    repeat (3) @(negedge clk);
    check("idle.busy", int'(busy_a), 0);

    // Small configs with a buffer: every pattern fails
`ifdef STOP_ON_ERR_EN
    q_b.push_back('{err: 1, pass: 0, idx: 0, edges: 3});
    q_c.push_back('{err: 1, pass: 0, idx: 0, edges: 3});
`else
    q_b.push_back('{err: 3, pass: 0, idx: 2, edges: 9});
    q_c.push_back('{err: 3, pass: 0, idx: 3, edges: 12});
`endif
    @(negedge clk);
    start_b = 1'b1;
    start_c = 1'b1;
    s_b = cyc + 1;
    s_c = cyc + 1;
    @(negedge clk);
    start_b = 1'b0;
    start_c = 1'b0;
    wait_bc("small");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
